// File: rtl/rv_pkg.sv
// Shared RISC-V datapath constants: widths, bubble instruction, opcode map, fetch FSM states.
// Imported by the fetch stage and the main control decoder.
package rv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } if_state_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/if_skid.sv
// One-entry instruction+PC holding register for a response that lands while the IF output is stalled.
// Latency: captured on the load edge, visible the cycle after. No backpressure of its own;
// the owner must not load while full (clear wins over load when both are asserted).
module if_skid
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [31:0]     wr_instr,
    output logic            full,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else begin
            if (load) begin
                full  <= 1'b1;
                pc    <= wr_pc;
                instr <= wr_instr;
            end
            if (unload || clear) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, fetches over imem req/ready, holds the word in the IF output register.
// Latency: if_instr updates on the edge imem_ready is sampled; 1 instr/cycle with zero-wait memory.
// Backpressure: stall holds the output; a response caught during stall parks in the skid and requests pause.
// Optional IFETCH_PERF_EN adds fetch and stall counters.
module instr_fetch #(
    parameter int              XLEN      = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic [6:0]      opcode
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    import rv_pkg::*;

    if_state_t       state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] drain_addr, drain_nxt;
    logic [XLEN-1:0] pc_inc, branch_pc;

    logic            valid_nxt;
    logic [XLEN-1:0] if_pc_nxt;
    logic [31:0]     instr_nxt;

    logic            flush, bubble, out_write;
    logic            skid_load, skid_unload, skid_clear, skid_full;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;

    assign pc_inc    = pc + XLEN'(4);
    assign branch_pc = {branch_target[XLEN-1:2], 2'b00};
    // DRAIN keeps presenting the abandoned address until its response retires.
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;
    assign opcode    = opcode_of(if_instr);

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        drain_nxt   = drain_addr;
        imem_req    = 1'b0;
        flush       = 1'b0;
        bubble      = 1'b0;
        out_write   = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    flush  = 1'b1;
                    pc_nxt = branch_pc;
                    if (!imem_ready) begin
                        drain_nxt = pc;
                        state_nxt = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_nxt = pc_inc;
                    if (stall && if_valid) begin
                        skid_load = 1'b1;
                        state_nxt = FULL;
                    end else begin
                        out_write = 1'b1;
                    end
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (branch_taken) pc_nxt = branch_pc;
                if (imem_ready) state_nxt = REQ;
            end
            FULL: begin
                if (branch_taken) begin
                    flush      = 1'b1;
                    skid_clear = 1'b1;
                    pc_nxt     = branch_pc;
                    state_nxt  = REQ;
                end else if (!stall && skid_full) begin
                    skid_unload = 1'b1;
                    out_write   = 1'b1;
                    state_nxt   = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_nxt = if_valid;
        if_pc_nxt = if_pc;
        instr_nxt = if_instr;
        if (flush || bubble) begin
            valid_nxt = 1'b0;
            instr_nxt = NOP_INSTR;
        end else if (out_write) begin
            valid_nxt = 1'b1;
            if (skid_unload) begin
                if_pc_nxt = skid_pc;
                instr_nxt = skid_instr;
            end else begin
                if_pc_nxt = pc;
                instr_nxt = imem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            if_valid   <= 1'b0;
            if_pc      <= RESET_PC;
            if_instr   <= NOP_INSTR;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_nxt;
            if_valid   <= valid_nxt;
            if_pc      <= if_pc_nxt;
            if_instr   <= instr_nxt;
        end
    end

    if_skid #(.XLEN(XLEN)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .unload   (skid_unload),
        .clear    (skid_clear),
        .wr_pc    (pc),
        .wr_instr (imem_rdata),
        .full     (skid_full),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (out_write) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall && if_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run checked against a program-order model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ready, branch_taken, stall, if_valid;
    logic [31:0] imem_addr, imem_rdata, branch_target, if_pc, if_instr;
    logic [6:0]  opcode;

    logic        w_rst_n = 1'b0;
    logic        w_req, w_ready, w_valid;
    logic [31:0] w_addr, w_rdata, w_pc, w_instr;
    logic [6:0]  w_opcode;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, w_pf, w_ps;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], 16'h0013};
    endfunction

    assign w_rdata = mem_word(w_addr);

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(32'h13)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .branch_taken(branch_taken),
        .branch_target(branch_target), .stall(stall), .if_valid(if_valid),
        .if_pc(if_pc), .if_instr(if_instr), .opcode(opcode)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h13)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .imem_ready(w_ready), .branch_taken(1'b0),
        .branch_target(32'h0), .stall(1'b0), .if_valid(w_valid),
        .if_pc(w_pc), .if_instr(w_instr), .opcode(w_opcode)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(w_pf), .perf_stall_cnt(w_ps)
`endif
    );

    task automatic drive(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt);
        imem_ready    = rdy;
        stall         = stl;
        branch_taken  = br;
        branch_target = tgt;
        imem_rdata    = mem_word(imem_addr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        imem_ready = 0; stall = 0; branch_taken = 0; branch_target = 0; imem_rdata = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        imem_ready = 0; stall = 0; branch_taken = 0; branch_target = 0; imem_rdata = 0;
        w_ready = 0;
        rst_n = 0; w_rst_n = 0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", if_pc); end
        n_checks++; if (if_instr !== 32'h13) begin n_fail++; $display("FAIL rst_instr: got %h want 13", if_instr); end
        n_checks++; if (opcode !== 7'b0010011) begin n_fail++; $display("FAIL rst_opcode: got %b want 0010011", opcode); end
        n_checks++; if (w_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_wrap_addr: got %h want fffffffc", w_addr); end
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got %b/%h want 1/0", imem_req, imem_addr); end
        drive(1, 0, 0, 0);
        n_checks++; if (imem_addr !== 32'h4 || if_valid !== 1'b1) begin n_fail++; $display("FAIL first_fetch: got %h/%b want 4/1", imem_addr, if_valid); end
        drive(0, 0, 0, 0);
        rst_n = 0;
        #1;
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_req: got %b/%h want 0/0", imem_req, imem_addr); end
        n_checks++; if (if_valid !== 1'b0 || if_instr !== 32'h13 || if_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_out: got %b/%h/%h want 0/13/0", if_valid, if_instr, if_pc); end
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (imem_addr !== 32'(4*i)) begin n_fail++; $display("FAIL seq_addr: got %h want %h", imem_addr, 32'(4*i)); end
            if (i > 0) begin
                e = mem_word(32'(4*(i-1)));
                n_checks++; if (if_pc !== 32'(4*(i-1)) || if_instr !== e || if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_out: got %h/%h want %h/%h", if_pc, if_instr, 32'(4*(i-1)), e); end
            end
            drive(1, 0, 0, 0);
        end
        e = mem_word(32'h8);
        n_checks++; if (imem_addr !== 32'hC || if_pc !== 32'h8) begin n_fail++; $display("FAIL seq_end: got %h/%h want c/8", imem_addr, if_pc); end
        n_checks++; if (opcode !== e[6:0]) begin n_fail++; $display("FAIL seq_opcode: got %b want %b", opcode, e[6:0]); end
    endtask

    task automatic test_wait_states();
        do_reset();
        repeat (2) begin
            drive(0, 0, 0, 0);
            n_checks++; if (imem_addr !== 32'h0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL wait_hold: got %h/%b want 0/0", imem_addr, if_valid); end
        end
        drive(1, 0, 0, 0);
        n_checks++; if (if_pc !== 32'h0 || if_valid !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL wait_resp: got %h/%b/%h want 0/1/4", if_pc, if_valid, imem_addr); end
        drive(0, 0, 0, 0);
        n_checks++; if (if_valid !== 1'b0 || if_instr !== 32'h13 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL wait_bubble: got %b/%h/%h want 0/13/4", if_valid, if_instr, imem_addr); end
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        n_checks++; if (if_pc !== 32'h4 || if_valid !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL wait_resp2: got %h/%b/%h want 4/1/8", if_pc, if_valid, imem_addr); end
    endtask

    task automatic test_stall_skid();
        logic [31:0] e;
        do_reset();
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL skid_pre: got %h want 8", imem_addr); end
        drive(1, 1, 0, 0);
        n_checks++; if (imem_req !== 1'b0 || if_pc !== 32'h4 || if_valid !== 1'b1) begin n_fail++; $display("FAIL skid_full: got %b/%h/%b want 0/4/1", imem_req, if_pc, if_valid); end
        drive(0, 1, 0, 0);
        n_checks++; if (imem_req !== 1'b0 || if_pc !== 32'h4) begin n_fail++; $display("FAIL skid_hold: got %b/%h want 0/4", imem_req, if_pc); end
        drive(0, 0, 0, 0);
        e = mem_word(32'h8);
        n_checks++; if (if_pc !== 32'h8 || if_instr !== e) begin n_fail++; $display("FAIL skid_out: got %h/%h want 8/%h", if_pc, if_instr, e); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL skid_resume: got %b/%h want 1/c", imem_req, imem_addr); end
    endtask

    task automatic test_branch_drain();
        logic [31:0] e;
        do_reset();
        repeat (8) drive(1, 0, 0, 0);
        n_checks++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL drain_pre: got %h want 20", imem_addr); end
        drive(0, 0, 1, 32'h100);
        n_checks++; if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin n_fail++; $display("FAIL drain_addr: got %h/%b want 20/1", imem_addr, imem_req); end
        n_checks++; if (if_valid !== 1'b0 || if_instr !== 32'h13 || if_pc !== 32'h1C) begin n_fail++; $display("FAIL drain_flush: got %b/%h/%h want 0/13/1c", if_valid, if_instr, if_pc); end
        drive(0, 0, 0, 0);
        n_checks++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL drain_hold: got %h want 20", imem_addr); end
        drive(1, 0, 0, 0);
        n_checks++; if (imem_addr !== 32'h100 || if_valid !== 1'b0 || if_instr !== 32'h13) begin n_fail++; $display("FAIL drain_done: got %h/%b/%h want 100/0/13", imem_addr, if_valid, if_instr); end
        drive(1, 0, 0, 0);
        e = mem_word(32'h100);
        n_checks++; if (if_pc !== 32'h100 || if_instr !== e || if_valid !== 1'b1) begin n_fail++; $display("FAIL drain_target: got %h/%h want 100/%h", if_pc, if_instr, e); end
    endtask

    task automatic test_branch_ready_stall();
        do_reset();
        drive(1, 0, 0, 0);
        drive(1, 1, 1, 32'h203);
        n_checks++; if (if_valid !== 1'b0 || if_instr !== 32'h13) begin n_fail++; $display("FAIL brs_flush: got %b/%h want 0/13", if_valid, if_instr); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL brs_addr: got %b/%h want 1/200", imem_req, imem_addr); end
        drive(1, 0, 0, 0);
        n_checks++; if (if_pc !== 32'h200 || if_valid !== 1'b1) begin n_fail++; $display("FAIL brs_target: got %h/%b want 200/1", if_pc, if_valid); end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        w_ready = 0;
        @(negedge clk);
        w_rst_n = 1;
        @(negedge clk);
        n_checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: got %b/%h want 1/fffffffc", w_req, w_addr); end
        w_ready = 1;
        @(negedge clk);
        e = mem_word(32'hFFFF_FFFC);
        n_checks++; if (w_addr !== 32'h0 || w_pc !== 32'hFFFF_FFFC || w_valid !== 1'b1 || w_instr !== e) begin n_fail++; $display("FAIL wrap_second: got %h/%h/%h want 0/fffffffc/%h", w_addr, w_pc, w_instr, e); end
        @(negedge clk);
        w_ready = 0;
        e = mem_word(32'h0);
        n_checks++; if (w_pc !== 32'h0 || w_addr !== 32'h4 || w_opcode !== e[6:0]) begin n_fail++; $display("FAIL wrap_third: got %h/%h/%b want 0/4/%b", w_pc, w_addr, w_opcode, e[6:0]); end
`ifdef IFETCH_PERF_EN
        n_checks++; if (w_pf !== 32'd2 || w_ps !== 32'd0) begin n_fail++; $display("FAIL wrap_perf: got %0d/%0d want 2/0", w_pf, w_ps); end
`endif
    endtask

    task automatic test_random();
        int          wait_left, consumed, flushed, stall_cycles;
        logic        prev_pend;
        logic [31:0] prev_addr, exp_pc, w;
        do_reset();
        exp_pc = 0; consumed = 0; flushed = 0; stall_cycles = 0;
        prev_pend = 0; prev_addr = 0;
        wait_left = $urandom_range(0, 2);
        for (int c = 0; c < 3000; c++) begin
            if (if_valid) begin
                w = mem_word(if_pc);
                n_checks++; if (if_instr !== w || opcode !== w[6:0]) begin n_fail++; $display("FAIL rand_instr: got %h want %h at pc %h", if_instr, w, if_pc); end
            end else begin
                n_checks++; if (if_instr !== 32'h13) begin n_fail++; $display("FAIL rand_bubble: got %h want 13", if_instr); end
            end
            if (prev_pend) begin
                n_checks++; if (imem_addr !== prev_addr) begin n_fail++; $display("FAIL rand_addr_hold: got %h want %h", imem_addr, prev_addr); end
            end
            stall         = ($urandom_range(0, 9) < 3);
            branch_taken  = (c > 2) && ($urandom_range(0, 29) == 0);
            branch_target = $urandom & 32'h0000_FFFF;
            if (imem_req) begin
                if (wait_left == 0) begin
                    imem_ready = 1;
                    wait_left  = $urandom_range(0, 2);
                end else begin
                    imem_ready = 0;
                    wait_left--;
                end
            end else begin
                imem_ready = 0;
            end
            imem_rdata = imem_ready ? mem_word(imem_addr) : $urandom;
            prev_pend  = imem_req && !imem_ready;
            prev_addr  = imem_addr;
            if (stall && if_valid) stall_cycles++;
            if (if_valid && !stall && !branch_taken) begin
                n_checks++; if (if_pc !== exp_pc) begin n_fail++; $display("FAIL rand_order: got %h want %h", if_pc, exp_pc); end
                exp_pc = exp_pc + 4;
                consumed++;
            end
            if (branch_taken) begin
                if (if_valid) flushed++;
                exp_pc = branch_target & 32'hFFFF_FFFC;
            end
            @(negedge clk);
        end
        n_checks++; if (consumed < 200) begin n_fail++; $display("FAIL rand_progress: got %0d want >=200", consumed); end
`ifdef IFETCH_PERF_EN
        n_checks++; if (perf_stall_cnt !== 32'(stall_cycles)) begin n_fail++; $display("FAIL rand_perf_stall: got %0d want %0d", perf_stall_cnt, stall_cycles); end
        n_checks++; if (perf_fetch_cnt !== 32'(consumed + flushed + (if_valid ? 1 : 0))) begin n_fail++; $display("FAIL rand_perf_fetch: got %0d want %0d", perf_fetch_cnt, consumed + flushed + (if_valid ? 1 : 0)); end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall_skid();
        test_branch_drain();
        test_branch_ready_stall();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the RISC-V simple datapath. Owns the PC and issues requests to instruction memory over a req/ready handshake. Holds the fetched word in an IF output register and drives its opcode field straight into the main `control` decoder. Handles branch redirect and flush, downstream stall, and a one-entry skid buffer, so a response arriving during a stall is never lost.

## Interface
- `XLEN`, 32, datapath and address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`).

- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  XLEN  fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_rdata`  in  32  instruction word; valid when `imem_ready`=1.
- `imem_ready`  in  1  response strobe; may assert in the same cycle as `imem_req`.
- `branch_taken`  in  1  redirect request (`branch` & ALU zero, from EX).
- `branch_target`  in  XLEN  redirect address.
- `stall`  in  1  downstream cannot accept; hold the IF output.
- `if_valid`  out  1  `if_instr` and `if_pc` hold a real instruction.
- `if_pc`  out  XLEN  PC of `if_instr`.
- `if_instr`  out  32  fetched instruction; `NOP_INSTR` when not valid.
- `opcode`  out  7  `if_instr[6:0]`, combinational, feeds `control`.

## Operation
- **FSM states:** IDLE, REQ, DRAIN, FULL.
- **IDLE:** entered on reset. Goes to REQ unconditionally on the next edge.
- **REQ:** `imem_req`=1, `imem_addr`=`pc`.
  - `branch_taken` & `imem_ready`: discard `imem_rdata`, `pc`←target, flush; stay in REQ.
  - `branch_taken` & !`imem_ready`: `drain_addr`←`pc`, `pc`←target, flush; go to DRAIN.
  - `imem_ready` & !(`stall` & `if_valid`): output←(`imem_rdata`, `pc`), `if_valid`←1, `pc`←`pc`+4.
  - `imem_ready` & `stall` & `if_valid`: skid←(`imem_rdata`, `pc`), `pc`←`pc`+4; go to FULL.
  - No response & !`stall`: `if_valid`←0, `if_instr`←`NOP_INSTR`.
- **FULL:** `imem_req`=0.
  - `branch_taken`: flush, clear skid, `pc`←target; go to REQ.
  - Else if !`stall`: output←skid, clear skid; go to REQ.
- **DRAIN:** `imem_req`=1, `imem_addr`=`drain_addr`. On `imem_ready`, discard the data and go to REQ.
  - `branch_taken` in DRAIN: `pc`←new target; stay in DRAIN.
- **Flush:** `if_valid`←0, `if_instr`←`NOP_INSTR`, `if_pc` unchanged.
- **Priority:** `branch_taken` > `stall` > normal advance.
- **PC arithmetic:** `pc`+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0. `branch_target` bits [1:0] are forced to 0.

## Timing
- **Reset values:** `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=`RESET_PC`, `if_instr`=`NOP_INSTR`, `opcode`=7'b0010011. Skid is empty and the state is IDLE.
- First `imem_req` is asserted 1 cycle after `rst_n` deasserts.
- **Latency:** `if_instr` updates on the edge where `imem_ready`=1. With zero-wait memory, throughput is 1 instruction per cycle.
- **Branch redirect:** the first request to the target issues on the next cycle from REQ. From DRAIN it issues on the cycle after the pending response.
- `rst_n` asserted mid-request: the request is abandoned, and all state and outputs return to reset values immediately.

## Configuration
- `IFETCH_PERF_EN` defined: adds outputs `perf_fetch_cnt` [31:0] and `perf_stall_cnt` [31:0], both reset to 0.
  - `perf_fetch_cnt` counts instructions written to the output register, including those coming from the skid.
  - `perf_stall_cnt` counts cycles with `stall` & `if_valid`.
  - Both counters wrap modulo 2^32.
- `IFETCH_PERF_EN` undefined: these ports and their logic are absent; behaviour is otherwise identical.

## Structure
- **Shared package `rv_pkg`:** FSM state enum, `NOP_INSTR`, `OPC_*` opcode constants (shared with `control`), and `XLEN`.
- **Sub-module `if_skid`:** one-entry instr+pc buffer with `load`/`unload`/`clear` controls. The FSM and PC logic stay in `instr_fetch`.

## Test plan
- **Reset and sequential fetch:** reset with `RESET_PC`=0, zero-wait memory → `imem_addr` 0,4,8 on consecutive cycles; `if_instr` follows 1 cycle behind; `opcode` is 0010011 during reset.
- **Wait states:** 2-cycle `imem_ready` delay → `imem_addr` held stable; `if_valid`=0 bubbles inserted.
- **Stall with in-flight response:** `stall`=1 while the response for addr 8 arrives → skid captures it, FSM is in FULL, `imem_req`=0. Releasing `stall` → `if_pc`=8 next cycle, fetch resumes at 12.
- **Branch with pending response:** `branch_taken` to 0x100 while the request for 0x20 waits → DRAIN holds addr 0x20; its data is discarded; the next request is 0x100; `if_instr`=`NOP_INSTR` in between.
- **Simultaneous branch, ready and stall:** `branch_taken`, `imem_ready` and `stall` all asserted → data discarded, skid stays empty, next address = target.
- **Wrap-around:** `RESET_PC`=32'hFFFF_FFFC → second fetch address is 0. With `IFETCH_PERF_EN` defined, `perf_fetch_cnt`=2.
